regfile_shadow: RTL and testbench
=================================

Name: regfile_shadow

Overview:
Parametrised, double-buffered configuration register file for the digital core.
- Host writes land in a shadow bank.
- A single commit strobe copies the whole shadow bank into the active bank that drives the analog/front-end config bits, so a multi-register update reaches the hardware atomically.
- Adds read-only status registers, a write lock, a dirty flag and address-range error reporting.

Parameters:
WIDTH, 8, bits per register
NUMREGS, 9, number of read/write config registers (addresses 0..NUMREGS-1)
NUMSTAT, 2, number of read-only status registers (addresses NUMREGS..NUMREGS+NUMSTAT-1)
ADDRW, 8, address width; NUMREGS+NUMSTAT <= 2**ADDRW
RESET_VAL, 0, reset value (WIDTH bits) loaded into every shadow and active register

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
config_bits  output  NUMREGS x WIDTH  active bank, drives hardware
write_addr  input  ADDRW  write address
write_data  input  WIDTH  write data
write  input  1  write request, single-cycle sampled
read_addr  input  ADDRW  read address
read  input  1  read request
read_src  input  1  0 = read shadow bank, 1 = read active bank (config addresses only)
status_in  input  NUMSTAT x WIDTH  live status values, sampled on read
commit  input  1  copy shadow to active
lock  input  1  high blocks all writes
read_data  output  WIDTH  registered read data
read_valid  output  1  one-cycle pulse, read_data valid
commit_done  output  1  one-cycle pulse after commit
dirty  output  1  shadow differs from active since last commit
err  output  1  one-cycle pulse on rejected access

Behaviour:
- Reset (async, reset_n low):
  - All shadow and active registers <= RESET_VAL.
  - read_data=0, read_valid=0, commit_done=0, dirty=0, err=0.
  - Reset asserted mid-commit or mid-read aborts the operation; no pulse follows deassertion.
- Accepted write (write=1, lock=0, write_addr<NUMREGS): shadow[write_addr] <= write_data at the clock edge. Active bank unchanged. dirty <= 1.
- Rejected write: write=1 and any of lock=1, write_addr in status range, write_addr >= NUMREGS+NUMSTAT.
  - No register changes.
  - err=1 in the following cycle only.
- Read (read=1): read_data and read_valid=1 appear in the cycle after the request (1-cycle latency).
  - Config address: returns shadow[addr] if read_src=0, active[addr] if read_src=1.
  - Status address: returns status_in[addr-NUMREGS] as sampled at the request edge; read_src ignored.
  - Out of range: read_data=0, read_valid=1, err=1.
  - With read=0, read_data holds its last value and read_valid=0.
- Commit (commit=1): active[i] <= shadow-next[i] for all i at the edge.
  - shadow-next includes any accepted write in the same cycle, so the write is committed.
  - commit_done=1 next cycle; dirty <= 0.
  - Commit while lock=1 is still performed; lock gates writes only.
- Read and write to the same address in the same cycle: read returns the pre-write value (read-before-write).
- Read with read_src=1 in the same cycle as commit: returns the pre-commit active value.
- Simultaneous write, read, commit: all three are processed independently per the rules above.
- err pulses once per cycle even if both the read and the write are rejected.
- Widths: addresses compared unsigned at full ADDRW. No wrap-around: address NUMREGS+NUMSTAT and above is an error, never aliased.

Test Plan:
- Reset, then read_src=1 read of addr 0..8 -> each read_data=RESET_VAL, read_valid pulse 1 cycle after each read; dirty=0.
- Write 0xA5 to addr 3 -> config_bits[3] still RESET_VAL, shadow read addr 3 = 0xA5, dirty=1; commit -> config_bits[3]=0xA5 the edge after commit, commit_done pulse, dirty=0.
- Write 0x3C to addr 8 with commit the same cycle -> config_bits[8]=0x3C after that edge, dirty=0.
- lock=1, write 0xFF to addr 1 -> err pulse, shadow[1] unchanged. Write to addr 9 (status) and to addr 200 -> err pulse each; read of addr 200 -> read_data=0, read_valid=1, err=1.
- status_in[0]=0x5A, read addr 9 -> read_data=0x5A. Change status_in to 0x11 and re-read -> 0x11.
- Write 0x77 to addr 2, then assert reset_n=0 mid-sequence with commit high -> all config_bits=RESET_VAL, no commit_done after release.

Source files
------------

// File: rtl/regfile_shadow.sv
// Double-buffered configuration register file: host writes land in a shadow bank,
// and a commit copies the whole shadow bank into the active bank in one edge.
module regfile_shadow #(
    parameter int               WIDTH     = 8,
    parameter int               NUMREGS   = 9,
    parameter int               NUMSTAT   = 2,
    parameter int               ADDRW     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [NUMREGS*WIDTH-1:0]   config_bits,
    input  logic [ADDRW-1:0]           write_addr,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       write,
    input  logic [ADDRW-1:0]           read_addr,
    input  logic                       read,
    input  logic                       read_src,
    input  logic [NUMSTAT*WIDTH-1:0]   status_in,
    input  logic                       commit,
    input  logic                       lock,
    output logic [WIDTH-1:0]           read_data,
    output logic                       read_valid,
    output logic                       commit_done,
    output logic                       dirty,
    output logic                       err
);

    // One extra bit keeps the range limits exact even when the map fills the address space.
    localparam logic [ADDRW:0] CFG_LIMIT = (ADDRW+1)'(NUMREGS);
    localparam logic [ADDRW:0] ALL_LIMIT = (ADDRW+1)'(NUMREGS + NUMSTAT);

    logic [WIDTH-1:0] shadow_q [NUMREGS];
    logic [WIDTH-1:0] shadow_d [NUMREGS];
    logic [WIDTH-1:0] active_q [NUMREGS];

    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             read_valid_q;
    logic             commit_done_q;
    logic             dirty_q, dirty_d;
    logic             err_q, err_d;

    logic             wr_ok;
    logic             wr_rej;
    logic             rd_oob;
    logic [WIDTH-1:0] rd_val;

    assign wr_ok  = write && !lock && ({1'b0, write_addr} < CFG_LIMIT);
    assign wr_rej = write && !wr_ok;
    assign rd_oob = read && ({1'b0, read_addr} >= ALL_LIMIT);

    // shadow_d already carries a same-cycle write, so a write plus commit is committed.
    genvar gi;
    generate
        for (gi = 0; gi < NUMREGS; gi++) begin : g_bank
            assign shadow_d[gi] = (wr_ok && (write_addr == ADDRW'(gi))) ? write_data : shadow_q[gi];
            assign config_bits[gi*WIDTH +: WIDTH] = active_q[gi];
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUMREGS; i++) begin
            if (read_addr == ADDRW'(i)) begin
                rd_val = read_src ? active_q[i] : shadow_q[i];
            end
        end
        for (int j = 0; j < NUMSTAT; j++) begin
            if (read_addr == ADDRW'(NUMREGS + j)) begin
                rd_val = status_in[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        read_data_d = read ? rd_val : read_data_q;
        err_d       = wr_rej || rd_oob;
        dirty_d     = dirty_q;
        if (commit) begin
            dirty_d = 1'b0;
        end else if (wr_ok) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUMREGS; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
            commit_done_q <= 1'b0;
            dirty_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < NUMREGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (commit) begin
                    active_q[i] <= shadow_d[i];
                end
            end
            read_data_q   <= read_data_d;
            read_valid_q  <= read;
            commit_done_q <= commit;
            dirty_q       <= dirty_d;
            err_q         <= err_d;
        end
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign commit_done = commit_done_q;
    assign dirty       = dirty_q;
    assign err         = err_q;

endmodule

// File: tb/tb_regfile_shadow.sv
// Self-checking bench for regfile_shadow: directed steps plus random traffic
// checked against a bank-level behavioural model.
module tb_regfile_shadow;

    localparam int NR = 9;
    localparam int NS = 2;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR*W-1:0] config_bits;
    logic [7:0]      write_addr;
    logic [7:0]      write_data;
    logic            write;
    logic [7:0]      read_addr;
    logic            read;
    logic            read_src;
    logic [NS*W-1:0] status_in;
    logic            commit;
    logic            lock;
    logic [7:0]      read_data;
    logic            read_valid;
    logic            commit_done;
    logic            dirty;
    logic            err;

    regfile_shadow #(.WIDTH(8), .NUMREGS(9), .NUMSTAT(2), .ADDRW(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .config_bits(config_bits),
        .write_addr(write_addr), .write_data(write_data), .write(write),
        .read_addr(read_addr), .read(read), .read_src(read_src),
        .status_in(status_in), .commit(commit), .lock(lock),
        .read_data(read_data), .read_valid(read_valid),
        .commit_done(commit_done), .dirty(dirty), .err(err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: two banks, status values, expected outputs.
    logic [7:0] sh [NR];
    logic [7:0] ac [NR];
    logic [7:0] st [NS];
    logic [7:0] e_rd;
    logic       e_rv, e_cd, e_dirty, e_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*W-1:0] model_cfg();
        logic [NR*W-1:0] v;
        for (int i = 0; i < NR; i++) v[i*W +: W] = ac[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            sh[i] = 8'h00;
            ac[i] = 8'h00;
        end
        e_rd = 8'h00; e_rv = 0; e_cd = 0; e_dirty = 0; e_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".read_valid"},  read_valid,  e_rv);
        if (e_rv) chk({tag, ".read_data"}, read_data, e_rd);
        chk({tag, ".err"},         err,         e_err);
        chk({tag, ".commit_done"}, commit_done, e_cd);
        chk({tag, ".dirty"},       dirty,       e_dirty);
        chk({tag, ".config_bits"}, config_bits, model_cfg());
    endtask

    // One clock of stimulus; the model applies read, then write, then commit.
    task automatic step(input string tag, input logic w, input logic [7:0] wa, input logic [7:0] wd,
                        input logic r, input logic [7:0] ra, input logic rs,
                        input logic c, input logic lk);
        write = w; write_addr = wa; write_data = wd;
        read = r; read_addr = ra; read_src = rs;
        commit = c; lock = lk;
        status_in = {st[1], st[0]};
        @(posedge clk);
        e_rv = r;
        e_err = 1'b0;
        if (r) begin
            if (ra < NR)           e_rd = rs ? ac[ra] : sh[ra];
            else if (ra < NR + NS) e_rd = st[ra - NR];
            else begin
                e_rd  = 8'h00;
                e_err = 1'b1;
            end
        end
        if (w) begin
            if (!lk && wa < NR) begin
                sh[wa]  = wd;
                e_dirty = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end
        if (c) begin
            for (int i = 0; i < NR; i++) ac[i] = sh[i];
            e_dirty = 1'b0;
        end
        e_cd = c;
        #1;
        check_all(tag);
        $display("step %-10s w=%0b wa=%0d wd=%02h r=%0b ra=%0d rs=%0b c=%0b lk=%0b -> rd=%02h rv=%0b err=%0b cd=%0b dirty=%0b",
                 tag, w, wa, wd, r, ra, rs, c, lk, read_data, read_valid, err, commit_done, dirty);
    endtask

    initial begin
        reset_n = 1'b0;
        write = 0; write_addr = 0; write_data = 0;
        read = 0; read_addr = 0; read_src = 0;
        commit = 0; lock = 0;
        st[0] = 8'h00; st[1] = 8'h00;
        status_in = '0;
        model_reset();
        #22;
        check_all("reset");
        chk("reset.read_data", read_data, 8'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < NR; a++) step("rd_act", 0, 0, 0, 1, 8'(a), 1, 0, 0);

        step("wr_a5",   1, 3, 8'hA5, 0, 0, 0, 0, 0);
        chk("wr_a5.cfg3_unchanged", config_bits[3*W +: W], 8'h00);
        step("rd_sh3",  0, 0, 0, 1, 3, 0, 0, 0);
        chk("rd_sh3.value", read_data, 8'hA5);
        step("commit",  0, 0, 0, 0, 0, 0, 1, 0);
        chk("commit.cfg3", config_bits[3*W +: W], 8'hA5);

        step("wr_cmt",  1, 8, 8'h3C, 0, 0, 0, 1, 0);
        chk("wr_cmt.cfg8", config_bits[8*W +: W], 8'h3C);

        step("lock_wr", 1, 1, 8'hFF, 0, 0, 0, 0, 1);
        step("rd_sh1",  0, 0, 0, 1, 1, 0, 0, 0);
        step("wr_stat", 1, 9, 8'h12, 0, 0, 0, 0, 0);
        step("wr_200",  1, 200, 8'h34, 0, 0, 0, 0, 0);
        step("rd_200",  0, 0, 0, 1, 200, 1, 0, 0);
        step("both_bad", 1, 10, 8'h56, 1, 11, 0, 0, 0);
        step("lock_cmt", 1, 4, 8'h99, 0, 0, 0, 1, 1);

        st[0] = 8'h5A;
        step("rd_st_5a", 0, 0, 0, 1, 9, 1, 0, 0);
        chk("rd_st_5a.value", read_data, 8'h5A);
        st[0] = 8'h11;
        step("rd_st_11", 0, 0, 0, 1, 9, 0, 0, 0);
        step("idle",     0, 0, 0, 0, 0, 0, 0, 0);

        step("rbw_wr",  1, 5, 8'hC3, 1, 5, 0, 0, 0);
        step("rac_cmt", 0, 0, 0, 1, 5, 1, 1, 0);
        step("rac_post", 0, 0, 0, 1, 5, 1, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [7:0] wa, ra;
            wa = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
            ra = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
            st[0] = 8'($urandom); st[1] = 8'($urandom);
            step("rand", 1'($urandom_range(0, 1)), wa, 8'($urandom),
                 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        step("wr_77", 1, 2, 8'h77, 0, 0, 0, 0, 0);
        commit = 1'b1; write = 1'b0; read = 1'b1; read_addr = 2; read_src = 0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk); #1;
        check_all("rst_hold");
        commit = 1'b0; read = 1'b0;
        reset_n = 1'b1;
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rd2", 0, 0, 0, 1, 2, 0, 0, 0);
        chk("post_rd2.value", read_data, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
